// File: rtl/edge_detector.sv
// Brings an asynchronous line into the sys_clk domain and emits a one-cycle strobe
// on the selected transition. Output is held quiet until the synchroniser has refilled after reset.
`timescale 1ns/100ps
module edge_detector #(
    parameter int FALL_EDGE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic sig,
    output logic edge_sig
);

    localparam int               CNT_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] ARM_CNT = CNT_W'(SYNC_STAGES + 1);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_stages
            $error("edge_detector: SYNC_STAGES must be in 2..8");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       arm_cnt_q, arm_cnt_d;
    logic                   edge_q, edge_d;
    logic                   sync_out;
    logic                   armed;
    logic                   detect;

    always_comb begin
        sync_out  = sync_q[SYNC_STAGES-1];
        armed     = (arm_cnt_q == ARM_CNT);
        detect    = (FALL_EDGE != 0) ? (~sync_out & prev_q) : (sync_out & ~prev_q);

        sync_d    = {sync_q[SYNC_STAGES-2:0], sig};
        prev_d    = sync_out;
        // Saturates at ARM_CNT so the strobe stays enabled until the next reset.
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + CNT_W'(1);
        edge_d    = detect & armed;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            arm_cnt_q <= '0;
            edge_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            arm_cnt_q <= arm_cnt_d;
            edge_q    <= edge_d;
        end
    end

    assign edge_sig = edge_q;

endmodule

// File: tb/tb_edge_detector.sv
// Drives three edge_detector configurations from one stimulus stream and compares each
// against a sample-history reference model, plus directed latency and pulse-count checks.
`timescale 1ns/100ps
module tb_edge_detector;

    logic clk = 1'b0;
    logic rst;
    logic sig;
    logic edge_f, edge_r, edge_r3;

    int   n_chk = 0;
    int   n_err = 0;

    // Reference state: index of last sys_clk edge, last edge that saw rst low, sampled sig history.
    int   n_edge   = 0;
    int   last_rst = -100;
    bit   seen_rst = 1'b0;
    logic hist [16];

    int   cnt_f = 0, cnt_r = 0, cnt_r3 = 0;
    int   b_f, b_r, b_r3;

    always #41.5 clk = ~clk;

    edge_detector #(.FALL_EDGE(1), .SYNC_STAGES(2)) dut_f (
        .sys_clk(clk), .rst(rst), .sig(sig), .edge_sig(edge_f));
    edge_detector #(.FALL_EDGE(0), .SYNC_STAGES(2)) dut_r (
        .sys_clk(clk), .rst(rst), .sig(sig), .edge_sig(edge_r));
    edge_detector #(.FALL_EDGE(0), .SYNC_STAGES(3)) dut_r3 (
        .sys_clk(clk), .rst(rst), .sig(sig), .edge_sig(edge_r3));

    always @(posedge clk) begin
        n_edge                  <= n_edge + 1;
        hist[(n_edge + 1) % 16] <= sig;
        if (rst === 1'b0) begin
            last_rst <= n_edge + 1;
            seen_rst <= 1'b1;
        end
    end

    // A pulse follows the edge that is s edges after a selected transition in the
    // sampled stream, unless fewer than s+2 edges have passed since the last reset.
    function automatic logic model_pulse(input int s, input logic rising);
        logic a, b;
        if (n_edge - last_rst < s + 2) return 1'b0;
        a = hist[(n_edge - s) % 16];
        b = hist[(n_edge - s - 1) % 16];
        return (a != b) && (a == rising);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #5;
    endtask

    task automatic rst_pulse();
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
    endtask

    task automatic snap();
        b_f  = cnt_f;
        b_r  = cnt_r;
        b_r3 = cnt_r3;
    endtask

    initial begin
        rst = 1'b0;
        sig = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (seen_rst) begin
                    chk("model_fall_s2", 32'(edge_f),  32'(model_pulse(2, 1'b0)));
                    chk("model_rise_s2", 32'(edge_r),  32'(model_pulse(2, 1'b1)));
                    chk("model_rise_s3", 32'(edge_r3), 32'(model_pulse(3, 1'b1)));
                    cnt_f  += int'(edge_f);
                    cnt_r  += int'(edge_r);
                    cnt_r3 += int'(edge_r3);
                end
            end
        join_none

        cyc(2);
        chk("reset_f",  32'(edge_f),  32'd0);
        chk("reset_r",  32'(edge_r),  32'd0);
        chk("reset_r3", 32'(edge_r3), 32'd0);
        rst = 1'b1;
        cyc(6);

        // Reset, wait 2, rise then fall with explicit latency checks.
        snap();
        rst_pulse();
        cyc(2);
        sig = 1'b1;
        repeat (3) @(negedge clk);
        chk("rise_lat_r",     32'(edge_r),  32'd1);
        chk("rise_none_f",    32'(edge_f),  32'd0);
        chk("rise_early_r3",  32'(edge_r3), 32'd0);
        @(negedge clk);
        chk("rise_width_r",   32'(edge_r),  32'd0);
        chk("rise_lat_r3",    32'(edge_r3), 32'd1);
        @(negedge clk);
        chk("rise_width_r3",  32'(edge_r3), 32'd0);
        #5;
        sig = 1'b0;
        repeat (3) @(negedge clk);
        chk("fall_lat_f",     32'(edge_f),  32'd1);
        chk("fall_none_r",    32'(edge_r),  32'd0);
        @(negedge clk);
        chk("fall_width_f",   32'(edge_f),  32'd0);
        cyc(4);
        chk("s1_cnt_f",  32'(cnt_f  - b_f),  32'd1);
        chk("s1_cnt_r",  32'(cnt_r  - b_r),  32'd1);
        chk("s1_cnt_r3", 32'(cnt_r3 - b_r3), 32'd1);

        // Level held high through reset must not produce a pulse.
        sig = 1'b1;
        cyc(6);
        snap();
        rst_pulse();
        cyc(6);
        chk("held_cnt_f",  32'(cnt_f  - b_f),  32'd0);
        chk("held_cnt_r",  32'(cnt_r  - b_r),  32'd0);
        chk("held_cnt_r3", 32'(cnt_r3 - b_r3), 32'd0);
        sig = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_fall_lat", 32'(edge_f), 32'd1);
        @(negedge clk);
        chk("held_fall_w",   32'(edge_f), 32'd0);
        cyc(4);
        chk("held_post_f", 32'(cnt_f - b_f), 32'd1);
        chk("held_post_r", 32'(cnt_r - b_r), 32'd0);

        // Periodic toggling with resets dropped in before toggles 7 and 15.
        for (int i = 0; i < 20; i++) begin
            if (i == 6 || i == 14) begin
                #200 rst = 1'b0;
                #83  rst = 1'b1;
                #66;
            end else begin
                #349;
            end
            sig = ~sig;
        end
        sig = 1'b0;
        cyc(8);

        // Sub-cycle glitch is never sampled; a level held across an edge is.
        snap();
        @(posedge clk);
        #10 sig = 1'b1;
        #10 sig = 1'b0;
        cyc(5);
        chk("glitch_f",  32'(cnt_f  - b_f),  32'd0);
        chk("glitch_r",  32'(cnt_r  - b_r),  32'd0);
        chk("glitch_r3", 32'(cnt_r3 - b_r3), 32'd0);
        sig = 1'b1;
        cyc(2);
        sig = 1'b0;
        cyc(6);
        chk("pulse_f",  32'(cnt_f  - b_f),  32'd1);
        chk("pulse_r",  32'(cnt_r  - b_r),  32'd1);
        chk("pulse_r3", 32'(cnt_r3 - b_r3), 32'd1);

        // Random levels, hold times and occasional resets.
        repeat (400) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b0;
                #($urandom_range(1, 170));
                rst = 1'b1;
            end
            sig = 1'($urandom_range(0, 1));
            #($urandom_range(3, 400));
        end
        sig = 1'b0;
        cyc(8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
